// File: rtl/camera_init_sequencer.sv
// camera_init_sequencer: power, reset and register-init sequencing
// for the camera array, with per-camera retry on a missed I2C ACK.
module camera_init_sequencer #(
  parameter int NUM_CAMS      = 2,
  parameter int PWDN_CYCLES   = 1000,
  parameter int RST_CYCLES    = 1000,
  parameter int SETTLE_CYCLES = 20000,
  parameter int MAX_RETRY     = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  output logic [NUM_CAMS-1:0] cam_pwdn_out,
  output logic [NUM_CAMS-1:0] cam_rst_n_out,
  output logic [NUM_CAMS-1:0] init_valid_out,
  input  logic [NUM_CAMS-1:0] init_ready_in,
  input  logic [NUM_CAMS-1:0] missed_ack_in,
  output logic                busy_out,
  output logic                done_out,
  output logic                error_out,
  output logic [1:0]          err_cam_out
);

  localparam int MAX_PR = (PWDN_CYCLES > RST_CYCLES) ?
                          PWDN_CYCLES : RST_CYCLES;
  localparam int MAX_D  = (MAX_PR > SETTLE_CYCLES) ?
                          MAX_PR : SETTLE_CYCLES;
  localparam int CW_RAW = $clog2(MAX_D + 1);
  localparam int CW     = (CW_RAW < 3) ? 3 : CW_RAW;
  localparam int RW     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] PWDN_LAST   = CW'(PWDN_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST    = CW'(3);
  localparam logic [1:0]    CAM_LAST    = 2'(NUM_CAMS - 1);
  localparam logic [RW-1:0] RTY_MAX     = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWDN,
    S_RST,
    S_SETTLE,
    S_REQ,
    S_RUN,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    cam_q, cam_d;
  logic [RW-1:0] rty_q, rty_d;
  logic          miss_q, miss_d;
  logic          low_q, low_d;
  logic [1:0]    err_q, err_d;
  logic [3:0]    rdy4, ack4, cam_oh;

  assign rdy4   = 4'(init_ready_in);
  assign ack4   = 4'(missed_ack_in);
  assign cam_oh = 4'b0001 << cam_q;

  // State, delay counter, camera index and retry bookkeeping.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cam_q   <= '0;
      rty_q   <= '0;
      miss_q  <= 1'b0;
      low_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q || !busy_out) ?
                 '0 : cnt_q + CW'(1);
      cam_q   <= cam_d;
      rty_q   <= rty_d;
      miss_q  <= miss_d;
      low_q   <= low_d;
      err_q   <= err_d;
    end
  end

  // Next-state: timed power phases, then one camera at a time.
  always_comb begin
    state_d = state_q;
    cam_d   = cam_q;
    rty_d   = rty_q;
    miss_d  = miss_q;
    low_d   = low_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_in) begin
          state_d = S_PWDN;
          cam_d   = '0;
          rty_d   = '0;
          err_d   = '0;
        end
      end
      S_PWDN: begin
        if (cnt_q == PWDN_LAST) state_d = S_RST;
      end
      S_RST: begin
        if (cnt_q == RST_LAST) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_REQ;
          miss_d  = 1'b0;
        end
      end
      S_REQ: begin
        if (ack4[cam_q]) miss_d = 1'b1;
        if (rdy4[cam_q]) begin
          state_d = S_RUN;
          low_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (ack4[cam_q]) miss_d = 1'b1;
        if (!rdy4[cam_q]) low_d = 1'b1;
        // Ready still high on the first cycles may be stale;
        // a writer that never drops ready is done after 4.
        if (rdy4[cam_q] && (low_q || cnt_q == RUN_LAST))
          state_d = S_CHECK;
      end
      S_CHECK: begin
        if (miss_q) begin
          if (rty_q < RTY_MAX) begin
            rty_d   = rty_q + RW'(1);
            state_d = S_PWDN;
          end else begin
            err_d   = cam_q;
            state_d = S_ERROR;
          end
        end else if (cam_q == CAM_LAST) begin
          state_d = S_DONE;
        end else begin
          cam_d   = cam_q + 2'd1;
          rty_d   = '0;
          miss_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    cam_pwdn_out   = '0;
    cam_rst_n_out  = '1;
    init_valid_out = '0;
    busy_out       = 1'b1;
    done_out       = 1'b0;
    error_out      = 1'b0;
    err_cam_out    = err_q;
    unique case (state_q)
      S_IDLE: begin
        cam_pwdn_out  = '1;
        cam_rst_n_out = '0;
        busy_out      = 1'b0;
      end
      S_PWDN: begin
        cam_pwdn_out  = '1;
        cam_rst_n_out = '0;
      end
      S_RST: cam_rst_n_out = '0;
      S_REQ: init_valid_out = cam_oh[NUM_CAMS-1:0];
      S_DONE: begin
        busy_out = 1'b0;
        done_out = 1'b1;
      end
      S_ERROR: begin
        cam_pwdn_out  = '1;
        cam_rst_n_out = '0;
        busy_out      = 1'b0;
        error_out     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_camera_init_sequencer.sv
// tb_camera_init_sequencer: randomized writer models, event
// scoreboard against a sequence-level reference model.
module tb_camera_init_sequencer;

  localparam int NC = 2;
  localparam int PW = 4;
  localparam int RS = 4;
  localparam int ST = 8;
  localparam int MR = 2;
  localparam logic [NC-1:0] ALL1 = '1;

  localparam int K_PWDN   = 0;
  localparam int K_RST    = 1;
  localparam int K_SETTLE = 2;
  localparam int K_HS     = 3;
  localparam int K_DONE   = 4;
  localparam int K_ERR    = 5;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [NC-1:0] cam_pwdn_out;
  logic [NC-1:0] cam_rst_n_out;
  logic [NC-1:0] init_valid_out;
  logic [NC-1:0] init_ready_in;
  logic [NC-1:0] missed_ack_in;
  logic          busy_out;
  logic          done_out;
  logic          error_out;
  logic [1:0]    err_cam_out;

  camera_init_sequencer #(
    .NUM_CAMS(NC), .PWDN_CYCLES(PW), .RST_CYCLES(RS),
    .SETTLE_CYCLES(ST), .MAX_RETRY(MR)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .cam_pwdn_out(cam_pwdn_out), .cam_rst_n_out(cam_rst_n_out),
    .init_valid_out(init_valid_out), .init_ready_in(init_ready_in),
    .missed_ack_in(missed_ack_in), .busy_out(busy_out),
    .done_out(done_out), .error_out(error_out),
    .err_cam_out(err_cam_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  string kn[6] = '{"pwdn_len", "rst_len", "settle_len",
                   "handshake", "done", "error"};

  ev_t expq[$];
  bit  plan[$];
  int  n_checks = 0;
  int  n_pass = 0;
  bit  mon_en = 1'b0;
  int  hold_force = 0;
  int  hs_idx = 0;

  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic void push_ev(int k, int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    expq.push_back(e);
  endfunction

  function automatic void push_phases();
    push_ev(K_PWDN, PW);
    push_ev(K_RST, RS);
    push_ev(K_SETTLE, ST);
  endfunction

  // Reference: walk the miss plan one handshake at a time.
  task automatic build_expect();
    int cam, rty, k;
    bit fin, miss;
    cam = 0; rty = 0; k = 0; fin = 1'b0;
    push_phases();
    while (!fin) begin
      push_ev(K_HS, 1 << cam);
      miss = (k < plan.size()) ? plan[k] : 1'b0;
      k++;
      if (miss && rty < MR) begin
        rty++;
        push_phases();
      end else if (miss) begin
        push_ev(K_ERR, cam * 256 + (int'(ALL1) << NC));
        fin = 1'b1;
      end else if (cam == NC - 1) begin
        push_ev(K_DONE, int'(ALL1));
        fin = 1'b1;
      end else begin
        cam++;
        rty = 0;
      end
    end
  endtask

  task automatic observe(int k, int v);
    ev_t e;
    if (expq.size() == 0) begin
      check("unexpected_event", k, -1);
      return;
    end
    e = expq.pop_front();
    check({kn[e.kind], "_kind"}, k, e.kind);
    check({kn[e.kind], "_val"}, v, e.val);
  endtask

  // Monitor: turns output activity into events.
  initial begin : monitor
    int   ph, cur, len;
    logic pdone, perr;
    cur = 3; len = 0; pdone = 1'b0; perr = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!mon_en || rst_in) begin
        cur = 3; len = 0;
        pdone = done_out; perr = error_out;
        continue;
      end
      if (busy_out && cam_pwdn_out == ALL1) ph = K_PWDN;
      else if (busy_out && cam_pwdn_out == '0 && cam_rst_n_out == '0)
        ph = K_RST;
      else if (busy_out && cam_rst_n_out == ALL1 &&
               init_valid_out == '0 && (cur == K_RST || cur == K_SETTLE))
        ph = K_SETTLE;
      else ph = 3;
      if (ph == cur && ph != 3) len++;
      else if (ph != cur) begin
        if (cur != 3) observe(cur, len);
        cur = ph;
        len = 1;
      end
      if ((init_valid_out & init_ready_in) != '0)
        observe(K_HS, int'(init_valid_out));
      if (done_out && !pdone)
        observe(K_DONE, int'({cam_pwdn_out, cam_rst_n_out}));
      if (error_out && !perr)
        observe(K_ERR, int'(err_cam_out) * 256 +
                int'({cam_pwdn_out, cam_rst_n_out}));
      pdone = done_out;
      perr  = error_out;
    end
  end

  // Register-writer models for all cameras plus ACK noise.
  initial begin : writer
    int hold[NC];
    int wstep, wcam, wlag, wbusy, wack, act, nc;
    bit wmiss;
    logic [NC-1:0] vprev;
    init_ready_in = '1; missed_ack_in = '0;
    wstep = -1; wcam = 0; wlag = 0; wbusy = 0; wack = 0; act = 0;
    wmiss = 1'b0; vprev = '0;
    foreach (hold[i]) hold[i] = 0;
    forever begin
      @(negedge clk_in); #1;
      missed_ack_in = '0;
      if (!busy_out) begin
        init_ready_in = '1;
        wstep = -1;
        vprev = '0;
        foreach (hold[i]) hold[i] = 0;
        continue;
      end
      for (int c = 0; c < NC; c++) if (init_valid_out[c]) act = c;
      if (wstep >= 0) begin
        wstep++;
        init_ready_in[wcam] =
          !(wbusy > 0 && wstep > wlag && wstep <= wlag + wbusy);
        if (wmiss && wstep == wack) missed_ack_in[wcam] = 1'b1;
        if (wstep > wlag + wbusy) wstep = -1;
      end else begin
        for (int c = 0; c < NC; c++) begin
          if (init_valid_out[c] && !vprev[c]) begin
            if (hold_force > 0) begin
              hold[c] = hold_force;
              hold_force = 0;
            end else if ($urandom_range(0, 3) == 0) begin
              hold[c] = int'($urandom_range(1, 12));
            end
          end
          if (hold[c] > 0) begin
            init_ready_in[c] = 1'b0;
            hold[c]--;
          end else begin
            init_ready_in[c] = 1'b1;
          end
        end
        for (int c = 0; c < NC; c++) begin
          if (init_valid_out[c] && init_ready_in[c]) begin
            wstep = 0;
            wcam  = c;
            wmiss = (hs_idx < plan.size()) ? plan[hs_idx] : 1'b0;
            hs_idx++;
            wlag  = int'($urandom_range(0, 1));
            wbusy = ($urandom_range(0, 4) == 0) ?
                    0 : int'($urandom_range(2, 12));
            wack  = (wbusy > 0) ? wlag + wbusy : 1;
          end
        end
      end
      if ($urandom_range(0, 5) == 0) begin
        nc = int'($urandom_range(0, NC - 1));
        if (nc != act) missed_ack_in[nc] = 1'b1;
      end
      vprev = init_valid_out;
    end
  end

  // mode 0 random, 1 clean + held-off, 2 retry cam 1, 3 exhaust cam 0
  task automatic do_run(int mode);
    int cyc, v0;
    bit fin;
    plan.delete();
    expq.delete();
    hs_idx = 0;
    for (int i = 0; i < 12; i++) begin
      case (mode)
        0: plan.push_back($urandom_range(0, 2) == 0);
        1: plan.push_back(1'b0);
        2: plan.push_back(i == 1);
        default: plan.push_back(1'b1);
      endcase
    end
    build_expect();
    if (mode == 1) hold_force = 20;
    mon_en = 1'b1;
    @(negedge clk_in); #1;
    start_in = 1'b1;
    @(negedge clk_in); #1;
    start_in = 1'b0;
    cyc = 0; v0 = 0; fin = 1'b0;
    do begin
      @(negedge clk_in); #1;
      cyc++;
      if (init_valid_out[0]) v0++;
      fin = done_out || error_out;
      start_in = !fin && busy_out && ($urandom_range(0, 19) == 0);
    end while (!fin && cyc < 1500);
    start_in = 1'b0;
    check("run_finished", int'(fin), 1);
    @(negedge clk_in); #1;
    check("events_left", expq.size(), 0);
    if (mode == 1) check("held_off_valid_cycles", v0, 21);
  endtask

  task automatic reset_mid_run();
    int cyc;
    bit hs;
    mon_en = 1'b0;
    plan.delete();
    expq.delete();
    hs_idx = 0;
    @(negedge clk_in); #1;
    start_in = 1'b1;
    @(negedge clk_in); #1;
    start_in = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk_in);
      hs = init_valid_out[0] && init_ready_in[0];
      cyc++;
    end while (!hs && cyc < 500);
    check("rst_test_handshake", int'(hs), 1);
    @(negedge clk_in); #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    check("midrun_rst_pwdn", int'(cam_pwdn_out), int'(ALL1));
    check("midrun_rst_rstn", int'(cam_rst_n_out), 0);
    check("midrun_rst_valid", int'(init_valid_out), 0);
    check("midrun_rst_busy", int'(busy_out), 0);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin : main
    rst_in = 1'b1;
    start_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_pwdn", int'(cam_pwdn_out), int'(ALL1));
    check("reset_rstn", int'(cam_rst_n_out), 0);
    check("reset_valid", int'(init_valid_out), 0);
    check("reset_busy", int'(busy_out), 0);
    check("reset_done", int'(done_out), 0);
    check("reset_error", int'(error_out), 0);
    check("reset_err_cam", int'(err_cam_out), 0);
    #1;
    rst_in = 1'b0;
    do_run(1);
    do_run(2);
    do_run(3);
    do_run(1);
    reset_mid_run();
    do_run(1);
    for (int r = 0; r < 20; r++) do_run(0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
